// File: rtl/alu_result_accumulator.sv
// Sums vec_len signed 8-bit ALU results into a signed ACC_WIDTH total on a valid/ready output.
// Define ACC_SATURATE_EN to clamp each addition to the signed range; without it the sum wraps.
module alu_result_accumulator #(
    parameter int ACC_WIDTH = 16,
    parameter int LEN_WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] vec_len,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_data,
    input  logic                 out_ready,
    output logic                 busy
);

    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_ACCUM | consuming elements until the counter runs out
    // ST_DONE  | presenting the final sum until out_ready
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [LEN_WIDTH-1:0] CNT_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;

    logic [ACC_WIDTH-1:0] in_ext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic                 xfer;

    assign in_ext = {{(ACC_WIDTH-8){in_data[7]}}, in_data};

`ifdef ACC_SATURATE_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic [ACC_WIDTH:0] sum_wide;

    // One guard bit: overflow when the two top bits disagree, direction from the guard bit.
    always_comb begin
        sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {in_ext[ACC_WIDTH-1], in_ext};
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            acc_sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_sum = sum_wide[ACC_WIDTH-1:0];
        end
    end
`else
    assign acc_sum = acc_q + in_ext;
`endif

    assign xfer = in_valid && (state_q == ST_ACCUM);

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (vec_len != '0) begin
                        cnt_d   = vec_len;
                        acc_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        out_data_d = '0;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_ACCUM: begin
                if (xfer) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        out_data_d = acc_sum;
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Directed, table-driven bench for alu_result_accumulator at ACC_WIDTH=10, LEN_WIDTH=4.
// Expected overflow results follow ACC_SATURATE_EN when the macro is defined for the build.
module tb_alu_result_accumulator;

    localparam int AW = 10;
    localparam int LW = 4;

`ifdef ACC_SATURATE_EN
    localparam longint EXP_POS_OVF = 511;
    localparam longint EXP_NEG_RAIL = -412;
    localparam longint EXP_NEG15 = -512;
`else
    localparam longint EXP_POS_OVF = -389;
    localparam longint EXP_NEG_RAIL = 484;
    localparam longint EXP_NEG15 = 274;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [AW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    alu_result_accumulator #(.ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .vec_len   (vec_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        int            n;
        logic [7:0]    d [16];
        longint        exp;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fill(input int idx, input string name, input int n, input int val, input longint exp);
        tbl[idx].name = name;
        tbl[idx].n    = n;
        tbl[idx].exp  = exp;
        for (int i = 0; i < 16; i++) tbl[idx].d[i] = (i < n) ? 8'(val) : 8'd0;
    endtask

    task automatic run_vec(input vec_t v);
        start   = 1'b1;
        vec_len = LW'(v.n);
        step();
        start = 1'b0;
        chk({v.name, "_in_ready"}, in_ready, (v.n != 0) ? 1 : 0);
        for (int i = 0; i < v.n; i++) begin
            in_valid = 1'b1;
            in_data  = v.d[i];
            step();
        end
        in_valid = 1'b0;
        chk({v.name, "_out_valid"}, out_valid, 1);
        chk({v.name, "_out_data"}, $signed(out_data), v.exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({v.name, "_busy_after"}, busy, 0);
    endtask

    initial begin
        fill(0, "basic", 3, 0, 13);
        tbl[0].d[0] = 8'd10;
        tbl[0].d[1] = 8'hFC;
        tbl[0].d[2] = 8'd7;
        fill(1, "zero_len", 0, 0, 0);
        fill(2, "pos_ovf", 5, 127, EXP_POS_OVF);
        fill(3, "neg_rail", 6, -128, EXP_NEG_RAIL);
        tbl[3].d[5] = 8'd100;
        fill(4, "single_neg", 1, -1, -1);
        fill(5, "max_len_pos", 15, 30, 450);
        fill(6, "max_len_neg", 15, -50, EXP_NEG15);
        fill(7, "exact_rail", 5, 127, 511);
        tbl[7].d[4] = 8'd3;
        fill(8, "mixed", 4, 0, -2);
        tbl[8].d[0] = 8'h80;
        tbl[8].d[1] = 8'd127;
        tbl[8].d[2] = 8'hFF;
        tbl[8].d[3] = 8'd0;

        // Reset held two cycles, with start asserted to confirm reset wins.
        start   = 1'b1;
        vec_len = 4'd3;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        start = 1'b0;
        reset = 1'b1;
        step();
        chk("idle_busy", busy, 0);

        for (int t = 0; t < 9; t++) run_vec(tbl[t]);

        // Stalls on input, ignored start in ACCUM, backpressure in DONE.
        start   = 1'b1;
        vec_len = 4'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd5;
        step();
        in_valid  = 1'b0;
        start     = 1'b1;
        vec_len   = 4'd7;
        out_ready = 1'b1;
        step();
        chk("stall_in_ready", in_ready, 1);
        chk("stall_out_valid", out_valid, 0);
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h80;
        step();
        in_data = 8'd99;
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_out_data", $signed(out_data), -123);
            chk("bp_in_ready", in_ready, 0);
            if (i < 3) step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        step();
        chk("bp_release_busy", busy, 0);
        chk("bp_release_valid", out_valid, 0);
        start     = 1'b0;
        out_ready = 1'b0;
        step();
        chk("done_start_ignored", busy, 0);

        // Abort mid-vector with reset; the next vector must not see residue.
        start   = 1'b1;
        vec_len = 4'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd50;
        step();
        step();
        in_valid = 1'b0;
        reset    = 1'b0;
        step();
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_busy", busy, 0);
        reset = 1'b1;
        step();
        begin
            vec_t v;
            v.name = "after_abort";
            v.n    = 1;
            v.exp  = 3;
            for (int i = 0; i < 16; i++) v.d[i] = 8'd0;
            v.d[0] = 8'd3;
            run_vec(v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
